led_sys_ctrl: RTL and testbench
===============================

Name: led_sys_ctrl

Overview:
- Command-side initiator that drives the `system_en` enable line consumed by the LED blinker blocks.
- Synchronises and debounces a raw active-low push-button and produces a one-cycle press pulse.
- A two-state FSM toggles `system_en` on each debounced press.
- Optional auto-off timer forces `system_en` low after a fixed run time.

Parameters:
- `DEB_MAX`, 32'd999_999: debounce hold count; a changed level must persist DEB_MAX+1 cycles (20 ms at 50 MHz).
- `TIMEOUT_MAX`, 32'd499_999_999: auto-off run time in cycles minus 1 (10 s at 50 MHz). Used only with LED_SYS_AUTO_OFF_EN.

Ports:
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `key_n`  input  1  raw push-button; asynchronous to clk; low = pressed.
- `system_en`  output  1  registered enable to LED blocks; 1 = blinking enabled.
- `key_flag`  output  1  registered one-cycle pulse per debounced press.

Behaviour:
- Reset values:
  - `system_en`=0, `key_flag`=0.
  - Synchroniser flops `sync1`/`sync2`=1.
  - Debounced level `key_stable`=1.
  - Debounce counter=0, timeout counter=0.
  - FSM=IDLE.
- Reset is honoured mid-operation: any active count, timer or RUN state is discarded immediately.
- Synchroniser: `key_n` -> `sync1` -> `sync2`. No other logic samples `key_n`.
- Debounce, each cycle:
  - `sync2`==`key_stable`: counter<=0.
  - Mismatch and counter<DEB_MAX: counter<=counter+1.
  - Mismatch and counter==DEB_MAX: `key_stable`<=`sync2`, counter<=0.
  - Any bounce back to equality before the limit clears the counter. No partial credit is kept.
- `key_flag`:
  - <=1 exactly on the edge where `key_stable` updates 1->0; <=0 otherwise.
  - Release (0->1) produces no flag.
- Latency: `key_n` held low from before clk edge 1 gives:
  - `key_flag`=1 after edge DEB_MAX+3;
  - `system_en` updated after edge DEB_MAX+4.
- FSM states: IDLE (`system_en`=0), RUN (`system_en`=1). `system_en` is the registered state output.
  - IDLE + `key_flag` -> RUN.
  - RUN + `key_flag` -> IDLE.
  - Otherwise hold.
- Holding the button produces exactly one toggle. Press again only after a debounced release.
- Counter widths: 32 bit unsigned; compare with ==, no wrap possible.

Optional Feature:
- Macro: LED_SYS_AUTO_OFF_EN.
- Defined:
  - Timeout counter clears whenever FSM≠RUN, and on the IDLE->RUN transition.
  - In RUN it increments each cycle. When ==TIMEOUT_MAX, FSM -> IDLE and counter<=0.
  - Simultaneous `key_flag` and timeout in RUN: FSM -> IDLE once; the two events do not cancel out.
  - A `key_flag` in RUN before timeout exits normally.
- Undefined:
  - Timeout counter and logic are absent.
  - RUN persists until the next press.
  - TIMEOUT_MAX is ignored.

Decomposition:
- Package `led_sys_pkg`:
  - FSM state encoding constants (IDLE=1'b0, RUN=1'b1);
  - default DEB_MAX/TIMEOUT_MAX values;
  - CLK_FREQ 50_000_000 constant.
- Sub-module `key_debounce`:
  - params DEB_MAX;
  - ports clk, rst_n, key_n -> key_flag, key_stable;
  - contains the synchroniser, debounce counter and flag logic.
- `led_sys_ctrl` instantiates `key_debounce` and holds the FSM and optional timer.

Test Plan:
- Reset (DEB_MAX=4, macro undefined): hold rst_n=0 with key_n=0 -> system_en=0, key_flag=0. Release rst_n with key_n=1 -> both stay 0 for 50 cycles.
- Clean press, DEB_MAX=4:
  - key_n 1->0 before edge 1, held 40 cycles -> key_flag=1 only after edge 7, exactly one cycle; system_en=1 after edge 8.
  - Release, then press again -> system_en=0.
- Bounce: key_n toggled 0/1 every 3 cycles for 30 cycles, then held 1 (DEB_MAX=4) -> key_flag never asserts; system_en stays 0.
- Long hold: press held 1000 cycles -> exactly one key_flag; system_en=1 for the whole hold.
- Auto-off, macro defined, DEB_MAX=4, TIMEOUT_MAX=19:
  - Press -> system_en=1 for exactly 20 cycles, then 0.
  - A second press issued so its key_flag coincides with the timeout cycle -> system_en=0 and stays 0.
- Reset mid-RUN: rst_n pulsed low while system_en=1 and timer at 10 -> system_en=0 asynchronously. After release, the next press yields a full 20-cycle run.

Source files
------------

// File: rtl/led_sys_ctrl_pkg.sv
// led_sys_pkg: FSM encoding, timing defaults and clock constant shared by led_sys_ctrl
package led_sys_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  localparam logic [31:0] CLK_FREQ        = 32'd50_000_000;
  localparam logic [31:0] DEB_MAX_DEF     = 32'd999_999;
  localparam logic [31:0] TIMEOUT_MAX_DEF = 32'd499_999_999;
endpackage

// File: rtl/led_sys_ctrl_if.sv
// led_sys_ctrl_if: button input and enable/flag outputs between the controller and its user
interface led_sys_ctrl_if;
  logic key_n;
  logic system_en;
  logic key_flag;
  modport master (output key_n, input system_en, input key_flag);
  modport slave (input key_n, output system_en, output key_flag);
endinterface

// File: rtl/led_sys_ctrl_key_debounce.sv
// key_debounce: synchronises and debounces an active-low button, pulsing key_flag once per press
module key_debounce
  import led_sys_pkg::*;
#(
  parameter logic [31:0] DEB_MAX = DEB_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_flag,
  output logic key_stable
);
  logic        r_sync1, r_sync2, r_stable, r_flag;
  logic [31:0] r_cnt;
  // two-flop synchroniser; idle level is released (1)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {r_sync1, r_sync2} <= 2'b11;
    else {r_sync1, r_sync2} <= {key_n, r_sync1};
  // accept a new level only after DEB_MAX+1 consecutive mismatching cycles; flag only the press
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b1;
      r_flag   <= 1'b0;
    end else begin
      r_flag <= 1'b0;
      if (r_sync2 == r_stable) r_cnt <= '0;
      else if (r_cnt < DEB_MAX) r_cnt <= r_cnt + 32'd1;
      else begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_flag   <= ~r_sync2;
      end
    end
  assign key_flag   = r_flag;
  assign key_stable = r_stable;
endmodule

// File: rtl/led_sys_ctrl.sv
// led_sys_ctrl: toggles system_en on each debounced press; LED_SYS_AUTO_OFF_EN adds an auto-off timer
module led_sys_ctrl
  import led_sys_pkg::*;
#(
  parameter logic [31:0] DEB_MAX     = DEB_MAX_DEF,
  parameter logic [31:0] TIMEOUT_MAX = TIMEOUT_MAX_DEF
) (
  input logic           clk,
  input logic           rst_n,
  led_sys_ctrl_if.slave bus
);
  logic   w_key_flag, w_key_stable, w_unused;
  state_t r_state;
  key_debounce #(.DEB_MAX(DEB_MAX)) u_deb (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (bus.key_n),
    .key_flag  (w_key_flag),
    .key_stable(w_key_stable)
  );
`ifdef LED_SYS_AUTO_OFF_EN
  logic [31:0] r_tmo;
  // press or expired run time both return to IDLE exactly once; the timer only counts in RUN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_tmo   <= '0;
    end else if (r_state == RUN) begin
      if (w_key_flag || r_tmo == TIMEOUT_MAX) begin
        r_state <= IDLE;
        r_tmo   <= '0;
      end else r_tmo <= r_tmo + 32'd1;
    end else begin
      r_tmo <= '0;
      if (w_key_flag) r_state <= RUN;
    end
  assign w_unused = w_key_stable;
`else
  // each debounced press flips between IDLE and RUN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else if (w_key_flag) r_state <= (r_state == RUN) ? IDLE : RUN;
  assign w_unused = w_key_stable ^ (^TIMEOUT_MAX);
`endif
  assign bus.system_en = r_state;
  assign bus.key_flag  = w_key_flag;
endmodule

// File: tb/tb_led_sys_ctrl.sv
// tb_led_sys_ctrl: randomized and directed checks of led_sys_ctrl against a behavioural model
module tb_led_sys_ctrl;
  localparam logic [31:0] DEB = 32'd4;
  localparam logic [31:0] TMO = 32'd19;
`ifdef LED_SYS_AUTO_OFF_EN
  localparam bit AUTO_OFF = 1'b1;
`else
  localparam bit AUTO_OFF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  led_sys_ctrl_if bus ();
  led_sys_ctrl #(.DEB_MAX(DEB), .TIMEOUT_MAX(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  // model: button seen two edges late; a level counts once it differs for DEB+1 cycles in a row
  bit [1:0] m_pipe;
  bit m_level, m_flag, m_en;
  int m_run, m_on;

  task automatic model_reset();
    m_pipe = 2'b11; m_level = 1'b1; m_flag = 1'b0; m_en = 1'b0; m_run = 0; m_on = 0;
  endtask

  task automatic model_edge(input bit k);
    bit seen, flag_nxt;
    seen = m_pipe[1];
    m_pipe = {m_pipe[0], k};
    flag_nxt = 1'b0;
    if (seen != m_level) begin
      m_run++;
      if (m_run == int'(DEB) + 1) begin
        m_level = seen; m_run = 0; flag_nxt = !seen;
      end
    end else m_run = 0;
    if (m_en) begin
      if (m_flag || (AUTO_OFF && m_on == int'(TMO) + 1)) begin m_en = 1'b0; m_on = 0; end
      else m_on++;
    end else if (m_flag) begin
      m_en = 1'b1; m_on = 1;
    end
    m_flag = flag_nxt;
  endtask

  task automatic step(input bit k);
    bus.key_n = k;
    @(posedge clk);
    if (rst_n) model_edge(k);
    @(negedge clk);
  endtask

  task automatic hold_reset();
    rst_n = 1'b0; bus.key_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    bus.key_n = 1'b0; rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.system_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", bus.system_en); end
    n_cmp++;
    if (bus.key_flag !== 1'b0) begin n_bad++; $display("FAIL reset_flag: got %b want 0", bus.key_flag); end
    bus.key_n = 1'b1; rst_n = 1'b1; model_reset();
    for (int i = 1; i <= 50; i++) begin
      step(1'b1);
      n_cmp++;
      if ({bus.system_en, bus.key_flag} !== 2'b00) begin
        n_bad++; $display("FAIL post_reset cyc %0d: got en=%b flag=%b want 0 0", i, bus.system_en, bus.key_flag);
      end
    end
  endtask

  task automatic test_clean_press();
    for (int i = 1; i <= 40; i++) begin
      step(1'b0);
      n_cmp++;
      if (bus.key_flag !== (i == 7)) begin
        n_bad++; $display("FAIL press_flag edge %0d: got %b want %b", i, bus.key_flag, i == 7);
      end
      n_cmp++;
      if (bus.system_en !== (i >= 8 && (!AUTO_OFF || i < 28))) begin
        n_bad++; $display("FAIL press_en edge %0d: got %b want %b", i, bus.system_en, i >= 8 && (!AUTO_OFF || i < 28));
      end
    end
    for (int i = 0; i < 60; i++) begin
      step(i < 30 ? 1'b1 : 1'b0);
      n_cmp++;
      if ({bus.system_en, bus.key_flag} !== {m_en, m_flag}) begin
        n_bad++; $display("FAIL repress cyc %0d: got en=%b flag=%b want %b %b", i, bus.system_en, bus.key_flag, m_en, m_flag);
      end
    end
    n_cmp++;
    if (bus.system_en !== 1'b0) begin n_bad++; $display("FAIL repress_off: got %b want 0", bus.system_en); end
    repeat (20) step(1'b1);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 50; i++) begin
      step(i < 30 ? bit'((i / 3) % 2) : 1'b1);
      n_cmp++;
      if ({bus.system_en, bus.key_flag} !== 2'b00) begin
        n_bad++; $display("FAIL bounce cyc %0d: got en=%b flag=%b want 0 0", i, bus.system_en, bus.key_flag);
      end
    end
  endtask

  task automatic test_long_hold();
    int flags;
    flags = 0;
    for (int i = 1; i <= 1000; i++) begin
      step(1'b0);
      flags += int'(bus.key_flag);
      n_cmp++;
      if (bus.system_en !== (i >= 8 && (!AUTO_OFF || i < 28))) begin
        n_bad++; $display("FAIL hold_en edge %0d: got %b want %b", i, bus.system_en, i >= 8 && (!AUTO_OFF || i < 28));
      end
    end
    n_cmp++;
    if (flags != 1) begin n_bad++; $display("FAIL hold_flags: got %0d want 1", flags); end
    repeat (20) step(1'b1);
  endtask

  task automatic test_random();
    bit lvl;
    int len;
    for (int s = 0; s < 120; s++) begin
      lvl = bit'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      for (int j = 0; j < len; j++) begin
        step(lvl);
        n_cmp++;
        if ({bus.system_en, bus.key_flag} !== {m_en, m_flag}) begin
          n_bad++; $display("FAIL random seg %0d: got en=%b flag=%b want %b %b", s, bus.system_en, bus.key_flag, m_en, m_flag);
        end
      end
    end
    repeat (20) step(1'b1);
  endtask

  task automatic test_reset_mid_run();
    int on_cnt;
    hold_reset();
    repeat (18) step(1'b0);
    n_cmp++;
    if (bus.system_en !== 1'b1) begin n_bad++; $display("FAIL midrun_pre: got %b want 1", bus.system_en); end
    rst_n = 1'b0; bus.key_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.system_en !== 1'b0) begin n_bad++; $display("FAIL midrun_async: got %b want 0", bus.system_en); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; model_reset();
    repeat (10) step(1'b1);
    on_cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      step(1'b0);
      on_cnt += int'(bus.system_en);
      n_cmp++;
      if ({bus.system_en, bus.key_flag} !== {m_en, m_flag}) begin
        n_bad++; $display("FAIL midrun_after edge %0d: got en=%b flag=%b want %b %b", i, bus.system_en, bus.key_flag, m_en, m_flag);
      end
    end
    n_cmp++;
    if (on_cnt != (AUTO_OFF ? 20 : 53)) begin n_bad++; $display("FAIL midrun_len: got %0d want %0d", on_cnt, AUTO_OFF ? 20 : 53); end
    repeat (20) step(1'b1);
  endtask

`ifdef LED_SYS_AUTO_OFF_EN
  task automatic test_auto_off();
    int on_cnt;
    hold_reset();
    on_cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      step(i <= 40 ? 1'b0 : 1'b1);
      on_cnt += int'(bus.system_en);
      n_cmp++;
      if (bus.system_en !== m_en) begin n_bad++; $display("FAIL auto_off edge %0d: got %b want %b", i, bus.system_en, m_en); end
    end
    n_cmp++;
    if (on_cnt != 20) begin n_bad++; $display("FAIL auto_off_len: got %0d want 20", on_cnt); end
  endtask

  task automatic test_coincide();
    hold_reset();
    for (int i = 1; i <= 60; i++) begin
      step(i <= 8 ? 1'b0 : (i <= 20 ? 1'b1 : 1'b0));
      n_cmp++;
      if (bus.key_flag !== (i == 7 || i == 27)) begin
        n_bad++; $display("FAIL coincide_flag edge %0d: got %b want %b", i, bus.key_flag, i == 7 || i == 27);
      end
      n_cmp++;
      if (bus.system_en !== (i >= 8 && i < 28)) begin
        n_bad++; $display("FAIL coincide_en edge %0d: got %b want %b", i, bus.system_en, i >= 8 && i < 28);
      end
    end
    repeat (20) step(1'b1);
  endtask
`endif

  initial begin
    bus.key_n = 1'b0;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_random();
    test_reset_mid_run();
`ifdef LED_SYS_AUTO_OFF_EN
    test_auto_off();
    test_coincide();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
